// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory request/acknowledge bundle between the fetch stage and
// the instruction memory.
//
//   imem_req   : fetch request valid (fetch stage -> memory)
//   imem_addr  : word-aligned fetch address, stable until acknowledged
//   imem_ack   : imem_rdata valid this cycle (memory -> fetch stage)
//   imem_rdata : fetched instruction word
//
// Modports:
//   master : fetch stage side (drives req/addr)
//   slave  : memory side (drives ack/rdata)
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch and IF/ID pipeline register for the 5-stage MIPS core.
// Owns the PC, runs the instruction-memory handshake, applies branch/jump
// redirects from decode and holds or bubbles IF/ID under the decode stall.
//
// State table:
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_REQ     | request to aF outstanding; ack delivers the word
//   ST_HOLD    | word received under stall, parked in hbuf; no request
//   ST_DISCARD | request to aF is stale (redirected); wait for its ack and
//              | drop the word, then refetch from pcF
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low
//   stallD     : IF/ID must hold this cycle
//   pcsrc      : taken branch resolved in decode
//   jump       : jump decoded in decode (priority over pcsrc)
//   pcbranch   : branch target from decode
//   imem       : instruction-memory handshake (master side)
//   instrD     : IF/ID instruction
//   pcplus4D   : IF/ID PC+4 of instrD
//   validD     : instrD is a real fetched instruction (0 = bubble)
//   op         : instrD[31:26]
//   funct      : instrD[5:0]
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stallD,
    input  logic          pcsrc,
    input  logic          jump,
    input  logic [31:0]   pcbranch,
    fetch_stage_if.master imem,
    output logic [31:0]   instrD,
    output logic [31:0]   pcplus4D,
    output logic          validD,
    output logic [5:0]    op,
    output logic [5:0]    funct
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] pc_f;
    logic [31:0] pc_f_n;
    logic [31:0] a_f;
    logic [31:0] a_f_n;
    logic [31:0] hbuf;
    logic [31:0] hbuf_n;

    logic        redir;
    logic [31:0] target;
    logic [31:0] a_f_plus4;
    logic        ack;

    // IF/ID load controls: at most one of load_word / load_bubble is set;
    // neither set means IF/ID holds.
    logic        load_word;
    logic        load_bubble;
    logic [31:0] word_instr;

    // Branch targets are word aligned; the low two bits carry no meaning.
    logic        unused_pcbranch_lsb;
    assign unused_pcbranch_lsb = ^pcbranch[1:0];

    assign redir     = (pcsrc | jump) & ~stallD;
    assign target    = jump ? {pcplus4D[31:28], instrD[25:0], 2'b00}
                            : {pcbranch[31:2], 2'b00};
    assign a_f_plus4 = a_f + 32'd4;

    // No request is issued in HOLD, so any ack seen there is not ours.
    assign ack = imem.imem_ack & (state != ST_HOLD);

    assign imem.imem_req  = reset & (state != ST_HOLD);
    assign imem.imem_addr = a_f;

    assign op    = instrD[31:26];
    assign funct = instrD[5:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_REQ;
            pc_f  <= RESET_PC_ALIGNED;
            a_f   <= RESET_PC_ALIGNED;
            hbuf  <= 32'd0;
        end else begin
            state <= state_n;
            pc_f  <= pc_f_n;
            a_f   <= a_f_n;
            hbuf  <= hbuf_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_f_n      = pc_f;
        a_f_n       = a_f;
        hbuf_n      = hbuf;
        load_word   = 1'b0;
        load_bubble = 1'b0;
        word_instr  = imem.imem_rdata;

        case (state)
            ST_REQ: begin
                if (ack) begin
                    if (redir) begin
                        pc_f_n      = target;
                        a_f_n       = target;
                        load_bubble = 1'b1;
                    end else if (stallD) begin
                        hbuf_n  = imem.imem_rdata;
                        state_n = ST_HOLD;
                    end else begin
                        load_word = 1'b1;
                        pc_f_n    = a_f_plus4;
                        a_f_n     = a_f_plus4;
                    end
                end else begin
                    if (redir) begin
                        // The request to aF must still complete; remember
                        // where to go once it does.
                        pc_f_n      = target;
                        state_n     = ST_DISCARD;
                        load_bubble = 1'b1;
                    end else if (!stallD) begin
                        load_bubble = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (redir) begin
                    pc_f_n      = target;
                    a_f_n       = target;
                    state_n     = ST_REQ;
                    load_bubble = 1'b1;
                end else if (!stallD) begin
                    word_instr = hbuf;
                    load_word  = 1'b1;
                    pc_f_n     = a_f_plus4;
                    a_f_n      = a_f_plus4;
                    state_n    = ST_REQ;
                end
            end

            ST_DISCARD: begin
                if (redir) begin
                    pc_f_n = target;
                end
                if (ack) begin
                    a_f_n   = redir ? target : pc_f;
                    state_n = ST_REQ;
                end
                if (!stallD) begin
                    load_bubble = 1'b1;
                end
            end

            default: begin
                state_n = ST_REQ;
            end
        endcase
    end

    // IF/ID register; the word's PC+4 is always the address it was fetched
    // from (aF) plus 4.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instrD   <= 32'd0;
            pcplus4D <= 32'd0;
            validD   <= 1'b0;
        end else if (load_bubble) begin
            instrD   <= 32'd0;
            pcplus4D <= 32'd0;
            validD   <= 1'b0;
        end else if (load_word) begin
            instrD   <= word_instr;
            pcplus4D <= a_f_plus4;
            validD   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. The memory model answers addr+1, except
// address 0xC which holds a jump word (32'h0800_0040, target 0x100).
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stallD;
    logic        pcsrc;
    logic        jump;
    logic [31:0] pcbranch;
    logic [31:0] instrD;
    logic [31:0] pcplus4D;
    logic        validD;
    logic [5:0]  op;
    logic [5:0]  funct;

    logic        ack_en;
    logic        ack_force;

    int tests  = 0;
    int failed = 0;

    fetch_stage_if imem();

    assign imem.imem_ack   = ack_force | (imem.imem_req & ack_en);
    assign imem.imem_rdata = (imem.imem_addr == 32'h0000_000C) ? 32'h0800_0040
                                                               : imem.imem_addr + 32'd1;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .stallD   (stallD),
        .pcsrc    (pcsrc),
        .jump     (jump),
        .pcbranch (pcbranch),
        .imem     (imem),
        .instrD   (instrD),
        .pcplus4D (pcplus4D),
        .validD   (validD),
        .op       (op),
        .funct    (funct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        reset     = 1'b0;
        stallD    = 1'b0;
        pcsrc     = 1'b0;
        jump      = 1'b0;
        pcbranch  = 32'd0;
        ack_en    = 1'b1;
        ack_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        // ---- reset values, zero-wait streaming, wait states ----
        hold_reset();
        chk("rst_req",      {31'd0, imem.imem_req}, 32'd0);
        chk("rst_addr",     imem.imem_addr, 32'd0);
        chk("rst_instr",    instrD, 32'd0);
        chk("rst_pcplus4",  pcplus4D, 32'd0);
        chk("rst_valid",    {31'd0, validD}, 32'd0);
        chk("rst_op",       {26'd0, op}, 32'd0);
        chk("rst_funct",    {26'd0, funct}, 32'd0);
        release_reset();
        chk("a_req_rise",   {31'd0, imem.imem_req}, 32'd1);
        chk("a_addr0",      imem.imem_addr, 32'd0);
        step();
        chk("a_instr1",     instrD, 32'd1);
        chk("a_pc4",        pcplus4D, 32'd4);
        chk("a_valid1",     {31'd0, validD}, 32'd1);
        chk("a_addr4",      imem.imem_addr, 32'd4);
        step();
        chk("a_instr5",     instrD, 32'd5);
        chk("a_pc8",        pcplus4D, 32'd8);
        chk("a_funct5",     {26'd0, funct}, 32'd5);
        chk("a_addr8_c0",   imem.imem_addr, 32'd8);
        ack_en = 1'b0;
        step();
        chk("a_addr8_c1",   imem.imem_addr, 32'd8);
        chk("a_req_c1",     {31'd0, imem.imem_req}, 32'd1);
        chk("a_bubble_c1",  {31'd0, validD}, 32'd0);
        step();
        chk("a_addr8_c2",   imem.imem_addr, 32'd8);
        chk("a_req_c2",     {31'd0, imem.imem_req}, 32'd1);
        chk("a_bubble_c2",  {31'd0, validD}, 32'd0);
        ack_en = 1'b1;
        step();
        chk("a_instr9",     instrD, 32'd9);
        chk("a_pc12",       pcplus4D, 32'd12);
        chk("a_valid9",     {31'd0, validD}, 32'd1);
        chk("a_addr12",     imem.imem_addr, 32'd12);

        // ---- stall for 3 cycles at ack of addr 4 ----
        hold_reset();
        release_reset();
        step();
        chk("b_instr1",     instrD, 32'd1);
        stallD = 1'b1;
        step();
        chk("b_req_s1",     {31'd0, imem.imem_req}, 32'd0);
        chk("b_instr_s1",   instrD, 32'd1);
        step();
        chk("b_req_s2",     {31'd0, imem.imem_req}, 32'd0);
        chk("b_instr_s2",   instrD, 32'd1);
        step();
        chk("b_req_s3",     {31'd0, imem.imem_req}, 32'd0);
        chk("b_instr_s3",   instrD, 32'd1);
        chk("b_valid_s3",   {31'd0, validD}, 32'd1);
        stallD = 1'b0;
        step();
        chk("b_instr5",     instrD, 32'd5);
        chk("b_pc8",        pcplus4D, 32'd8);
        chk("b_valid5",     {31'd0, validD}, 32'd1);
        chk("b_addr8",      imem.imem_addr, 32'd8);
        chk("b_req_back",   {31'd0, imem.imem_req}, 32'd1);

        // ---- branch while request to 8 is unacked, then wrap at top ----
        hold_reset();
        release_reset();
        step();
        step();
        chk("c_instr5",     instrD, 32'd5);
        ack_en   = 1'b0;
        pcsrc    = 1'b1;
        pcbranch = 32'h0000_0100;
        step();
        chk("c_addr_stale1", imem.imem_addr, 32'd8);
        chk("c_req_stale1",  {31'd0, imem.imem_req}, 32'd1);
        chk("c_bubble1",     {31'd0, validD}, 32'd0);
        pcsrc = 1'b0;
        step();
        chk("c_addr_stale2", imem.imem_addr, 32'd8);
        chk("c_bubble2",     {31'd0, validD}, 32'd0);
        ack_en = 1'b1;
        step();
        chk("c_drop_valid",  {31'd0, validD}, 32'd0);
        chk("c_drop_instr",  instrD, 32'd0);
        chk("c_addr_tgt",    imem.imem_addr, 32'h0000_0100);
        step();
        chk("c_instr101",    instrD, 32'h0000_0101);
        chk("c_pc104",       pcplus4D, 32'h0000_0104);
        chk("c_valid101",    {31'd0, validD}, 32'd1);
        pcsrc    = 1'b1;
        pcbranch = 32'hFFFF_FFFF;
        step();
        chk("c_addr_top",    imem.imem_addr, 32'hFFFF_FFFC);
        chk("c_bubble_top",  {31'd0, validD}, 32'd0);
        pcsrc = 1'b0;
        step();
        chk("c_instr_top",   instrD, 32'hFFFF_FFFD);
        chk("c_pc_wrap",     pcplus4D, 32'd0);
        chk("c_addr_wrap",   imem.imem_addr, 32'd0);

        // ---- jump from IF/ID, unstalled ----
        hold_reset();
        release_reset();
        repeat (4) step();
        chk("d_instr_j",     instrD, 32'h0800_0040);
        chk("d_pc10",        pcplus4D, 32'h0000_0010);
        chk("d_op",          {26'd0, op}, 32'd2);
        chk("d_funct",       {26'd0, funct}, 32'd0);
        chk("d_addr10",      imem.imem_addr, 32'h0000_0010);
        jump = 1'b1;
        step();
        chk("d_addr_jtgt",   imem.imem_addr, 32'h0000_0100);
        chk("d_bubble",      {31'd0, validD}, 32'd0);
        chk("d_bubble_ins",  instrD, 32'd0);
        jump = 1'b0;
        step();
        chk("d_instr101",    instrD, 32'h0000_0101);
        chk("d_valid101",    {31'd0, validD}, 32'd1);

        // ---- jump masked by stall ----
        hold_reset();
        release_reset();
        repeat (4) step();
        stallD = 1'b1;
        jump   = 1'b1;
        step();
        chk("e_req_hold",    {31'd0, imem.imem_req}, 32'd0);
        chk("e_instr_held",  instrD, 32'h0800_0040);
        chk("e_addr_held",   imem.imem_addr, 32'h0000_0010);
        stallD = 1'b0;
        jump   = 1'b0;
        step();
        chk("e_instr11",     instrD, 32'h0000_0011);
        chk("e_pc14",        pcplus4D, 32'h0000_0014);
        chk("e_addr14",      imem.imem_addr, 32'h0000_0014);

        // ---- reset pulsed mid-DISCARD ----
        hold_reset();
        release_reset();
        step();
        ack_en   = 1'b0;
        pcsrc    = 1'b1;
        pcbranch = 32'h0000_0200;
        step();
        pcsrc = 1'b0;
        chk("f_addr_stale",  imem.imem_addr, 32'd4);
        chk("f_req_stale",   {31'd0, imem.imem_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("f_rst_req",     {31'd0, imem.imem_req}, 32'd0);
        chk("f_rst_addr",    imem.imem_addr, 32'd0);
        chk("f_rst_instr",   instrD, 32'd0);
        chk("f_rst_valid",   {31'd0, validD}, 32'd0);
        ack_force = 1'b1;
        step();
        chk("f_late_valid",  {31'd0, validD}, 32'd0);
        chk("f_late_addr",   imem.imem_addr, 32'd0);
        ack_force = 1'b0;
        ack_en    = 1'b1;
        release_reset();
        chk("f_restart_req",  {31'd0, imem.imem_req}, 32'd1);
        chk("f_restart_addr", imem.imem_addr, 32'd0);
        step();
        chk("f_instr1",      instrD, 32'd1);
        chk("f_pc4",         pcplus4D, 32'd4);
        chk("f_addr4",       imem.imem_addr, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core. It owns the PC and drives the instruction-memory request/acknowledge handshake. It presents the decoded-stage instruction, whose op/funct fields feed the controller. It applies redirects from the controller's branch (`pcsrc`) and `jump` outputs, and holds or bubbles IF/ID under the decode-stall signal from the hazard unit.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Bits [1:0] are ignored and treated as 0.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low.
- `stallD` input 1: IF/ID must hold its contents this cycle.
- `pcsrc` input 1: taken branch resolved in decode.
- `jump` input 1: jump decoded in decode.
- `pcbranch` input 32: branch target from decode.
- `imem_req` output 1: fetch request valid.
- `imem_addr` output 32: fetch address; held stable while `imem_req`=1 and not acknowledged.
- `imem_ack` input 1: `imem_rdata` is valid this cycle. Ignored when `imem_req`=0.
- `imem_rdata` input 32: fetched instruction word.
- `instrD` output 32: IF/ID instruction.
- `pcplus4D` output 32: IF/ID PC+4 of `instrD`.
- `validD` output 1: `instrD` is a real fetched instruction (0 = bubble).
- `op` output 6: `instrD[31:26]`.
- `funct` output 6: `instrD[5:0]`.

## Operation
- Registers:
  - `pcF`: next address to fetch.
  - `aF`: address of the outstanding request; drives `imem_addr`.
  - `hbuf`: 32-bit hold buffer.
  - `state`.
  - IF/ID: `instrD`, `pcplus4D`, `validD`.
- Redirect: `redir = (pcsrc | jump) & ~stallD`.
  - Target is `{pcplus4D[31:28], instrD[25:0], 2'b00}` if `jump`, else `{pcbranch[31:2], 2'b00}`.
  - `jump` has priority over `pcsrc`.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- IF/ID update rule: if `stallD`=1, hold. Otherwise load exactly one of:
  - a bubble (`instrD`=0, `validD`=0, `pcplus4D`=0), or
  - a word (`validD`=1, `pcplus4D`=fetch address+4).
- `redir` always loads a bubble.
- State REQ: `imem_req`=1.
  - `imem_ack` & `redir`: drop the word; `pcF`, `aF` <= target; stay REQ.
  - `imem_ack` & `stallD`: `hbuf` <= `imem_rdata`; go HOLD.
  - `imem_ack` otherwise: IF/ID <= word; `pcF`, `aF` <= `aF`+4; stay REQ.
  - No ack & `redir`: `pcF` <= target; `aF` unchanged; go DISCARD.
  - No ack otherwise: stay REQ. IF/ID gets a bubble unless `stallD`.
- State HOLD: `imem_req`=0.
  - `redir`: drop `hbuf`; `pcF`, `aF` <= target; go REQ.
  - `~stallD`: IF/ID <= `hbuf` with `pcplus4D`=`aF`+4; `pcF`, `aF` <= `aF`+4; go REQ.
  - Otherwise: stay HOLD.
- State DISCARD: `imem_req`=1, `imem_addr`=`aF` (stale request completing).
  - A further `redir` updates `pcF` with the new target.
  - On `imem_ack`: drop the word; `aF` <= `pcF` (or the new target if `redir` in the same cycle); go REQ.
  - IF/ID gets a bubble unless `stallD`.
- `imem_req` is forced to 0 while `reset`=0.

## Timing
- Reset (async, `reset`=0):
  - `state`=REQ, `pcF`=`aF`=`RESET_PC`.
  - `instrD`=0, `pcplus4D`=0, `validD`=0, `op`=0, `funct`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
- `imem_req` rises combinationally after `reset` deasserts.
- Zero-wait memory (ack in the request cycle): one instruction per cycle. A word acked at edge n appears in `instrD` after edge n.
- Wait states: `imem_addr` is stable from request until ack. Each wait cycle inserts one bubble.
- Redirect penalty:
  - REQ with ack: 1 bubble.
  - REQ without ack: the remaining stale-request cycles, plus 1.
- `stallD` and `redir` are sampled the same cycle; `redir` is masked by `stallD`.
- Reset asserted mid-request or in HOLD/DISCARD: all state returns to reset values immediately. The outstanding request is abandoned; the memory side must tolerate this.

## Test plan
- Reset release, `RESET_PC`=0, zero-wait memory returning addr+1: `imem_addr` 0,4,8 on consecutive cycles. `instrD`=1,5,9 one cycle later; `pcplus4D`=4,8,12; `validD`=1.
- Ack delayed 2 cycles at addr 8: `imem_addr`=8 with `imem_req`=1 for 3 cycles; `validD`=0 for 2 cycles; then `instrD`=9, `pcplus4D`=12.
- `stallD`=1 for 3 cycles at ack of addr 4:
  - `imem_req`=0 and `instrD` unchanged during the stall.
  - First cycle after release: `instrD`=5, next `imem_addr`=8.
- `pcsrc`=1, `pcbranch`=32'h100 while request to 8 is unacked; ack 2 cycles later:
  - That word is never loaded.
  - Next request is `imem_addr`=32'h100.
  - `validD`=0 until `instrD`=32'h101.
- `jump`=1 with `instrD`=32'h0800_0040, `pcplus4D`=32'h0000_0010, `stallD`=0: next `imem_addr`=32'h0000_0100 and IF/ID gets a bubble. A repeat with `stallD`=1 causes no redirect.
- `reset` pulsed low mid-DISCARD: outputs at reset values immediately. After release, fetch restarts at `RESET_PC`; the late ack is ignored.
